// File: rtl/block_token_emitter.sv
// Serialises BEGIN/END/CHAR keyword tokens into space-terminated ASCII words
// and tracks begin/end nesting of the emitted stream.
module block_token_emitter #(
  parameter int unsigned MAX_DEPTH = 255,
  parameter int unsigned CASE_MODE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tok_valid,
  input  logic [1:0] tok_type,
  input  logic [7:0] tok_char,
  output logic       tok_ready,
  output logic [7:0] out_char,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] depth,
  output logic       balanced,
  output logic       underflow,
  output logic       overflow,
  output logic       bad_tok
);

  typedef enum logic [1:0] {IDLE, WORD, SEP} state_t;
  typedef enum logic [1:0] {K_BEGIN, K_END, K_CHAR} kind_t;

  localparam logic [7:0] SPACE     = 8'h20;
  localparam logic [7:0] DEPTH_MAX = 8'(MAX_DEPTH);

  state_t     state;
  kind_t      kind;
  kind_t      acc_kind;
  logic       upper;
  logic       toggle;
  logic       up_now;
  logic       accept;
  logic [2:0] idx;
  logic [7:0] chr;

  function automatic logic [7:0] letter(input kind_t k, input logic [2:0] i,
                                        input logic up, input logic [7:0] c);
    logic [7:0] l;
    l = c;
    case (k)
      K_BEGIN: begin
        case (i)
          3'd0:    l = "b";
          3'd1:    l = "e";
          3'd2:    l = "g";
          3'd3:    l = "i";
          default: l = "n";
        endcase
      end
      K_END: begin
        case (i)
          3'd0:    l = "e";
          3'd1:    l = "n";
          default: l = "d";
        endcase
      end
      default: l = c;
    endcase
    // keyword letters are all lowercase a-z, so uppercase is a fixed offset
    if (k != K_CHAR && up) l = l - 8'h20;
    return l;
  endfunction

  function automatic logic [2:0] last_idx(input kind_t k);
    case (k)
      K_BEGIN: return 3'd4;
      K_END:   return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  assign tok_ready = (state == IDLE) || (state == SEP && out_ready);
  assign accept    = tok_valid && tok_ready;
  assign out_valid = (state != IDLE);
  assign balanced  = (depth == '0) && !underflow;
  assign up_now    = (CASE_MODE == 1) || (CASE_MODE == 2 && toggle);

  always_comb begin
    acc_kind = K_BEGIN;
    if (tok_type == 2'b01)      acc_kind = K_END;
    else if (tok_type == 2'b10) acc_kind = K_CHAR;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      out_char  <= SPACE;
      depth     <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
      bad_tok   <= 1'b0;
      toggle    <= 1'b0;
      kind      <= K_CHAR;
      upper     <= 1'b0;
      idx       <= '0;
      chr       <= SPACE;
    end else begin
      bad_tok <= 1'b0;
      case (state)
        WORD: begin
          if (out_ready) begin
            if (idx == last_idx(kind)) begin
              state    <= SEP;
              out_char <= SPACE;
            end else begin
              idx      <= idx + 3'd1;
              out_char <= letter(kind, idx + 3'd1, upper, chr);
            end
          end
        end
        SEP: begin
          if (out_ready) begin
            state    <= IDLE;
            out_char <= SPACE;
            if (kind == K_BEGIN) begin
              if (depth == DEPTH_MAX) overflow <= 1'b1;
              else                    depth    <= depth + 8'd1;
            end else if (kind == K_END) begin
              if (depth == '0) underflow <= 1'b1;
              else             depth     <= depth - 8'd1;
            end
          end
        end
        default: ;
      endcase

      // An accept in SEP overrides the SEP->IDLE move above, chaining words without a gap.
      if (accept) begin
        kind  <= acc_kind;
        upper <= up_now;
        idx   <= '0;
        chr   <= tok_char;
        if (tok_type == 2'b11) begin
          bad_tok  <= 1'b1;
          state    <= IDLE;
          out_char <= SPACE;
        end else if (tok_type == 2'b10 && tok_char == SPACE) begin
          state    <= SEP;
          out_char <= SPACE;
        end else begin
          state    <= WORD;
          out_char <= letter(acc_kind, 3'd0, up_now, tok_char);
          if (CASE_MODE == 2 && tok_type != 2'b10) toggle <= ~toggle;
        end
      end
    end
  end

endmodule

// File: tb/tb_block_token_emitter.sv
// Bench for block_token_emitter: a lowercase instance and an alternating-case,
// shallow-depth instance driven in parallel and checked against a character-queue model.
module tb_block_token_emitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, tok_valid, out_ready;
  logic [1:0] tok_type;
  logic [7:0] tok_char;

  logic [1:0]       rdy, ov, bal, uf, of, bt;
  logic [1:0][7:0]  oc, dep;

  block_token_emitter #(.MAX_DEPTH(255), .CASE_MODE(0)) u0 (
    .clk(clk), .reset(reset), .tok_valid(tok_valid), .tok_type(tok_type), .tok_char(tok_char),
    .tok_ready(rdy[0]), .out_char(oc[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .depth(dep[0]), .balanced(bal[0]), .underflow(uf[0]), .overflow(of[0]), .bad_tok(bt[0])
  );

  block_token_emitter #(.MAX_DEPTH(3), .CASE_MODE(2)) u2 (
    .clk(clk), .reset(reset), .tok_valid(tok_valid), .tok_type(tok_type), .tok_char(tok_char),
    .tok_ready(rdy[1]), .out_char(oc[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .depth(dep[1]), .balanced(bal[1]), .underflow(uf[1]), .overflow(of[1]), .bad_tok(bt[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chks(input string name, input string got, input string exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=\"%s\" exp=\"%s\"", name, got, exp);
    end
  endtask

  function automatic string ch2s(input logic [7:0] c);
    string s;
    s = " ";
    s.putc(0, c);
    return s;
  endfunction

  // ---------------- reference model: queue of characters still owed ----------------
  typedef struct {
    logic [1:0][7:0] c;    // expected char for instance 0 / instance 1
    int              eff;  // 0 none, 1 begin completes, 2 end completes
  } ent_t;

  ent_t  q[$];
  int    m_depth[2];
  bit    m_uf[2], m_of[2];
  bit    m_tog   = 1'b0;
  bit    exp_bad = 1'b0;
  bit    mon_en  = 1'b0;
  int    maxd[2] = '{255, 3};
  string coll[2];
  int    vcnt = 0, bcnt = 0;

  bit    exp_v, exp_r, nb;
  ent_t  e;

  initial begin
    m_depth = '{0, 0};
    m_uf    = '{0, 0};
    m_of    = '{0, 0};
  end

  function automatic void push_word(input string w, input int eff, input bit up2);
    ent_t x;
    logic [7:0] ch;
    for (int i = 0; i < w.len(); i++) begin
      ch     = w[i];
      x.c[0] = ch;
      x.c[1] = up2 ? ch - 8'h20 : ch;
      x.eff  = 0;
      q.push_back(x);
    end
    x.c[0] = 8'h20;
    x.c[1] = 8'h20;
    x.eff  = eff;
    q.push_back(x);
  endfunction

  function automatic void push_char(input logic [7:0] ch);
    ent_t x;
    x.eff = 0;
    if (ch != 8'h20) begin
      x.c[0] = ch;
      x.c[1] = ch;
      q.push_back(x);
    end
    x.c[0] = 8'h20;
    x.c[1] = 8'h20;
    q.push_back(x);
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      exp_v = (q.size() != 0);
      exp_r = (q.size() == 0) || (q.size() == 1 && out_ready);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("out_valid%0d", i), 32'(ov[i]), 32'(exp_v));
        chk($sformatf("tok_ready%0d", i), 32'(rdy[i]), 32'(exp_r));
        if (exp_v) chk($sformatf("out_char%0d", i), 32'(oc[i]), 32'(q[0].c[i]));
        chk($sformatf("depth%0d", i), 32'(dep[i]), 32'(m_depth[i]));
        chk($sformatf("underflow%0d", i), 32'(uf[i]), 32'(m_uf[i]));
        chk($sformatf("overflow%0d", i), 32'(of[i]), 32'(m_of[i]));
        chk($sformatf("balanced%0d", i), 32'(bal[i]), 32'(m_depth[i] == 0 && !m_uf[i]));
        chk($sformatf("bad_tok%0d", i), 32'(bt[i]), 32'(exp_bad));
        if (ov[i] && out_ready) coll[i] = {coll[i], ch2s(oc[i])};
      end
      if (ov[0]) vcnt++;
      if (bt[0]) bcnt++;
      nb = 1'b0;
      if (!reset) begin
        q.delete();
        m_depth = '{0, 0};
        m_uf    = '{0, 0};
        m_of    = '{0, 0};
        m_tog   = 1'b0;
      end else begin
        if (exp_v && out_ready) begin
          e = q.pop_front();
          for (int i = 0; i < 2; i++) begin
            if (e.eff == 1) begin
              if (m_depth[i] == maxd[i]) m_of[i] = 1'b1;
              else                       m_depth[i]++;
            end else if (e.eff == 2) begin
              if (m_depth[i] == 0) m_uf[i] = 1'b1;
              else                 m_depth[i]--;
            end
          end
        end
        if (tok_valid && exp_r) begin
          case (tok_type)
            2'b00: begin push_word("begin", 1, m_tog); m_tog = !m_tog; end
            2'b01: begin push_word("end", 2, m_tog);   m_tog = !m_tog; end
            2'b10: push_char(tok_char);
            default: nb = 1'b1;
          endcase
        end
      end
      exp_bad = nb;
    end
  end

  // ---------------- drivers ----------------
  task automatic do_reset();
    reset     = 1'b0;
    tok_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic send(input logic [1:0] t, input logic [7:0] c);
    bit acc;
    int n;
    tok_valid = 1'b1;
    tok_type  = t;
    tok_char  = c;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = rdy[0];
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    tok_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (!ov[0]) done = 1'b1;
    end
    @(posedge clk); #1;
    if (!done) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_coll();
    coll[0] = "";
    coll[1] = "";
    vcnt    = 0;
    bcnt    = 0;
  endtask

  typedef struct {
    logic [1:0] t;
    logic [7:0] c;
    string      e0;
    string      e2;
    int         d;
    bit         u;
  } vec_t;

  vec_t vt[9];

  initial begin
    reset     = 1'b0;
    tok_valid = 1'b0;
    tok_type  = 2'b00;
    tok_char  = 8'h00;
    out_ready = 1'b1;
    clear_coll();
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    reset  = 1'b1;

    // one token at a time, each followed by its full word
    vt[0] = '{2'b00, 8'h00, "begin ", "begin ", 1, 1'b0};
    vt[1] = '{2'b01, 8'h00, "end ",   "END ",   0, 1'b0};
    vt[2] = '{2'b01, 8'h00, "end ",   "end ",   0, 1'b1};
    vt[3] = '{2'b10, "x",   "x ",     "x ",     0, 1'b1};
    vt[4] = '{2'b11, "z",   "",       "",       0, 1'b1};
    vt[5] = '{2'b10, 8'h20, " ",      " ",      0, 1'b1};
    vt[6] = '{2'b00, 8'h41, "begin ", "BEGIN ", 1, 1'b1};
    vt[7] = '{2'b10, "Q",   "Q ",     "Q ",     1, 1'b1};
    vt[8] = '{2'b01, 8'h00, "end ",   "end ",   0, 1'b1};

    chk("reset_out_char", 32'(oc[0]), 32'h20);
    chk("reset_depth", 32'(dep[0]), 32'd0);
    chk("reset_balanced", 32'(bal[0]), 32'd1);
    for (int i = 0; i < 9; i++) begin
      clear_coll();
      send(vt[i].t, vt[i].c);
      wait_idle();
      chks($sformatf("vec%0d_str0", i), coll[0], vt[i].e0);
      chks($sformatf("vec%0d_str2", i), coll[1], vt[i].e2);
      chk($sformatf("vec%0d_depth", i), 32'(dep[0]), 32'(vt[i].d));
      chk($sformatf("vec%0d_uf", i), 32'(uf[0]), 32'(vt[i].u));
    end

    // back-to-back BEGIN END: ten consecutive characters, no gap
    do_reset();
    clear_coll();
    send(2'b00, 8'h00);
    send(2'b01, 8'h00);
    chk("b2b_depth_mid", 32'(dep[0]), 32'd1);
    wait_idle();
    chks("b2b_str", coll[0], "begin end ");
    chk("b2b_valid_cycles", 32'(vcnt), 32'd10);
    chk("b2b_depth_end", 32'(dep[0]), 32'd0);
    chk("b2b_balanced", 32'(bal[0]), 32'd1);

    // END first: underflow sticks through a later balanced pair
    do_reset();
    clear_coll();
    send(2'b01, 8'h00);
    wait_idle();
    chks("uf_str", coll[0], "end ");
    chk("uf_flag", 32'(uf[0]), 32'd1);
    chk("uf_balanced", 32'(bal[0]), 32'd0);
    send(2'b00, 8'h00);
    send(2'b01, 8'h00);
    wait_idle();
    chk("uf_sticky_bal", 32'(bal[0]), 32'd0);

    // stall pattern during "begin"
    do_reset();
    clear_coll();
    send(2'b00, 8'h00);
    out_ready = 1'b1; @(posedge clk); #1;
    out_ready = 1'b0; @(posedge clk); #1;
    out_ready = 1'b0; @(posedge clk); #1;
    out_ready = 1'b1; @(posedge clk); #1;
    wait_idle();
    chks("stall_str", coll[0], "begin ");

    // alternating case
    do_reset();
    clear_coll();
    send(2'b00, 8'h00);
    send(2'b00, 8'h00);
    send(2'b01, 8'h00);
    send(2'b01, 8'h00);
    wait_idle();
    chks("alt_str2", coll[1], "begin BEGIN end END ");
    chks("alt_str0", coll[0], "begin begin end end ");
    chk("alt_depth", 32'(dep[1]), 32'd0);

    // CHAR, illegal, CHAR space
    do_reset();
    clear_coll();
    send(2'b10, "x");
    send(2'b11, 8'h00);
    send(2'b10, 8'h20);
    wait_idle();
    chks("char_str", coll[0], "x  ");
    chk("char_bad_pulses", 32'(bcnt), 32'd1);
    chk("char_depth", 32'(dep[0]), 32'd0);

    // reset mid-word
    do_reset();
    send(2'b00, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("midrst_valid", 32'(ov[0]), 32'd0);
    chk("midrst_depth", 32'(dep[0]), 32'd0);
    chk("midrst_ready", 32'(rdy[0]), 32'd1);
    chk("midrst_char", 32'(oc[0]), 32'h20);
    clear_coll();
    send(2'b01, 8'h00);
    wait_idle();
    chks("midrst_str", coll[0], "end ");
    chk("midrst_uf", 32'(uf[0]), 32'd1);

    // saturation at MAX_DEPTH=3 on the second instance
    do_reset();
    for (int i = 0; i < 4; i++) send(2'b00, 8'h00);
    wait_idle();
    chk("ovf_depth2", 32'(dep[1]), 32'd3);
    chk("ovf_flag2", 32'(of[1]), 32'd1);
    chk("ovf_depth0", 32'(dep[0]), 32'd4);
    chk("ovf_flag0", 32'(of[0]), 32'd0);

    // random traffic, checked cycle by cycle by the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom % 200) != 0;
      tok_valid = ($urandom % 3) != 0;
      tok_type  = 2'($urandom);
      tok_char  = (($urandom % 4) == 0) ? 8'h20 : 8'($urandom_range(33, 126));
      out_ready = ($urandom % 4) != 0;
      @(posedge clk); #1;
    end
    reset     = 1'b1;
    tok_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
